// File: rtl/mul_share_pkg.sv
// Shared types and defaults for the multiplier-sharing controller.
// Optional build macro: MUL_SHARE_SWAP_EN (operand ordering, see mul_share_ctrl).
package mul_share_pkg;

    localparam int DEF_W    = 16;
    localparam int DEF_NREQ = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LDA  = 3'd1,
        ST_LDB  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage

// File: rtl/mul_share_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping at NREQ. The pointer register lives in the caller.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    input  logic            en_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  id_o
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    logic              found;

    // Rotate so the pointer position sits at bit 0, then take the lowest set bit.
    assign dbl = {req_i, req_i};
    assign rot = NREQ'(dbl >> ptr_i);

    always_comb begin
        off   = '0;
        found = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
    end

    assign sum  = {1'b0, ptr_i} + {1'b0, off};
    assign id_o = (sum >= (IDW+1)'(NREQ)) ? IDW'(sum - (IDW+1)'(NREQ)) : sum[IDW-1:0];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_gnt
        assign gnt_o[gi] = en_i && found && (id_o == IDW'(gi));
    end

endmodule

// File: rtl/mul_share_ctrl.sv
// Round-robin sequencing controller sharing one repeated-addition multiplier.
// Build macro MUL_SHARE_SWAP_EN: load the larger operand as A to shorten RUN.
module mul_share_ctrl
    import mul_share_pkg::*;
#(
    parameter int NREQ = DEF_NREQ,
    parameter int W    = DEF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0] grant,
    output logic [W-1:0]    bus,
    output logic            ldA,
    output logic            ldB,
    output logic            ldP,
    output logic            clrP,
    output logic            decB,
    input  logic            eqz,
    input  logic [W-1:0]    p_in,
    output logic            rsp_valid,
    output logic [IDW-1:0]  rsp_id,
    output logic [W-1:0]    rsp_data,
    output logic            busy
);

    state_e          state_q, state_d;
    logic [IDW-1:0]  owner_q, owner_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [W-1:0]    rsp_data_q, rsp_data_d;

    logic [NREQ-1:0] arb_gnt;
    logic [IDW-1:0]  arb_id;

    logic [W-1:0] a_arr [NREQ];
    logic [W-1:0] b_arr [NREQ];
    logic [W-1:0] own_a, own_b, op_a, op_b;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = a_in[gi*W +: W];
        assign b_arr[gi] = b_in[gi*W +: W];
    end

    assign own_a = a_arr[owner_q];
    assign own_b = b_arr[owner_q];

`ifdef MUL_SHARE_SWAP_EN
    // Smaller operand becomes the loop count; a tie keeps the original order.
    assign op_a = (own_b > own_a) ? own_b : own_a;
    assign op_b = (own_b > own_a) ? own_a : own_b;
`else
    assign op_a = own_a;
    assign op_b = own_b;
`endif

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i (req),
        .ptr_i (ptr_q),
        .en_i  (state_q == ST_IDLE),
        .gnt_o (arb_gnt),
        .id_o  (arb_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            ptr_q      <= '0;
            rsp_id_q   <= '0;
            grant_q    <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            rsp_id_q   <= rsp_id_d;
            grant_q    <= grant_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        rsp_id_d   = rsp_id_q;
        grant_d    = grant_q;
        rsp_data_d = rsp_data_q;
        case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_LDA;
                    owner_d = arb_id;
                    grant_d = arb_gnt;
                    ptr_d   = (arb_id == IDW'(NREQ - 1)) ? '0 : arb_id + IDW'(1);
                end
            end
            ST_LDA:  state_d = ST_LDB;
            ST_LDB:  state_d = ST_RUN;
            ST_RUN: begin
                if (eqz) begin
                    state_d    = ST_DONE;
                    rsp_data_d = p_in;
                    rsp_id_d   = owner_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus       = '0;
        ldA       = 1'b0;
        ldB       = 1'b0;
        ldP       = 1'b0;
        clrP      = 1'b0;
        decB      = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            ST_LDA: begin
                bus = op_a;
                ldA = 1'b1;
            end
            ST_LDB: begin
                bus  = op_b;
                ldB  = 1'b1;
                clrP = 1'b1;
            end
            ST_RUN: begin
                ldP  = ~eqz;
                decB = ~eqz;
            end
            ST_DONE: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign grant    = grant_q;
    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Sequencing controller and round-robin arbiter that lets NREQ requesters share one repeated-addition multiplier datapath. The datapath has A, B and P registers, a shared data bus, decrement-B and an eqz flag. The block picks one requester, drives the operands onto the datapath bus and issues the load/clear/decrement strobes. It then returns the product tagged with the requester id. It sits between the client blocks and the multiplier datapath and replaces the single-user controller.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 16, operand, bus and product width; product truncated to W bits by the datapath
IDW, $clog2(NREQ), requester id width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
req  in  NREQ  per-requester level request; held with operands until its rsp_valid
a_in  in  NREQ*W  flattened multiplicand per requester (slice i = bits i*W +: W)
b_in  in  NREQ*W  flattened multiplier per requester
grant  out  NREQ  one-hot current owner; 0 when idle
bus  out  W  data bus into datapath A/B registers
ldA  out  1  load A from bus
ldB  out  1  load B from bus
ldP  out  1  P <= P + A
clrP  out  1  P <= 0
decB  out  1  B <= B - 1
eqz  in  1  datapath B register == 0
p_in  in  W  datapath P register
rsp_valid  out  1  one-cycle completion pulse
rsp_id  out  IDW  index of completed requester
rsp_data  out  W  product; holds until next completion
busy  out  1  state != IDLE

Behaviour:
- Reset: rst_n low at a clock edge forces IDLE, rr pointer 0, rsp_id 0, rsp_data 0. All strobes, grant, bus, rsp_valid and busy are 0 from that edge. This also applies mid-operation: no rsp_valid is issued for the aborted job.
- FSM states: IDLE, LDA, LDB, RUN, DONE.
- IDLE:
  - If any req is high, the round-robin arbiter picks the first set req at or after the pointer, wrapping at NREQ.
  - Register the winner id and one-hot grant, then go to LDA.
  - Pointer becomes winner+1 mod NREQ.
- LDA (1 cycle): bus = a of owner, ldA = 1.
- LDB (1 cycle): bus = b of owner, ldB = 1, clrP = 1; go to RUN.
- RUN:
  - Mealy outputs ldP = decB = ~eqz.
  - While eqz = 0, stay in RUN.
  - When eqz = 1, capture p_in into rsp_data and go to DONE.
  - RUN lasts b+1 cycles; b = 0 gives one RUN cycle with no add, so the product is 0.
- DONE (1 cycle): rsp_valid = 1, rsp_id = owner, grant still held; then go to IDLE.
- Latency: rsp_valid is high in the cycle after edge b+3, counting from the IDLE grant edge.
- Back-to-back jobs: minimum one IDLE cycle between DONE and the next LDA.
- Requester handshake: req must be low from the edge that ends its DONE cycle.
- req dropping mid-job is a protocol violation. The job still completes and pulses rsp_valid.
- Simultaneous requests: resolved strictly by the pointer, so no starvation.
- Arithmetic: bus is passed through unmodified. Overflow wraps modulo 2^W in the datapath; the controller does not flag it.
- Strobes are combinational decodes of the registered state, plus eqz in RUN. Only one of ldA/ldB is ever high.

Optional Feature:
MUL_SHARE_SWAP_EN:
- Defined: in LDA/LDB the controller drives max(a,b) as A and min(a,b) as B (unsigned compare; tie keeps order). RUN length becomes min(a,b)+1 cycles.
- Undefined: a always to A, b always to B; no comparator is synthesized.

Decomposition:
- mul_share_pkg: FSM state enum (3-bit: IDLE=0, LDA=1, LDB=2, RUN=3, DONE=4) and default W/NREQ constants.
- Sub-module rr_arbiter: parameter NREQ. Inputs req, pointer, enable; outputs one-hot grant and encoded id. Purely combinational; the pointer register stays in mul_share_ctrl.

Test Plan:
- Single job, req[0], a=5, b=3 -> LDA, LDB, then ldP/decB for 3 cycles, rsp_data=15, rsp_id=0, rsp_valid 6 cycles after grant edge.
- req[2], a=7, b=0 -> RUN one cycle with ldP=decB=0, rsp_data=0, rsp_valid 3 cycles after grant.
- req[3:0] all high, each holding until its response -> grants 0,1,2,3 in order. Re-raise req[0] and req[3] after job 1 completes -> order after 3 is 0 then 3 (pointer wraps correctly).
- W=16, a=300, b=300 -> rsp_data=24464 (90000 mod 65536).
- rst_n low for one cycle mid-RUN (a=9, b=50) -> next cycle all strobes/grant/busy 0, no rsp_valid, pointer 0. A fresh req[1] afterwards completes normally.
- With MUL_SHARE_SWAP_EN, a=2, b=100 -> bus carries 100 then 2, RUN 3 cycles, rsp_data=200. Without the macro -> RUN 101 cycles, same result.
